vend_controller: RTL

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_pkg.sv | 23 ++
 rtl/vend_controller_if.sv | 17 +
 rtl/vend_stock_bank.sv | 49 ++++
 rtl/vend_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding, tier/timeout defaults and width helper
package vend_pkg;

  localparam int DEF_PRICE_GROUP = 4;
  localparam int DEF_TIMEOUT     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RELOAD,
    ST_GETCODE,
    ST_VALIDATE,
    ST_TRANSACT,
    ST_VEND,
    ST_DOOR_OPEN_WAIT,
    ST_DOOR_CLOSE_WAIT
  } state_t;

  // Index width that stays legal (>= 1 bit) for degenerate counts.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vend_controller_if.sv
// rtl/vend_controller_if.sv - controller-to-stock-bank request/response bundle
interface vend_controller_if #(
  parameter int NUM_ITEMS = 20,
  parameter int IDX_W     = 5,
  parameter int STOCK_W   = 4
);

  logic                 reload;
  logic                 dec;
  logic [IDX_W-1:0]     idx;
  logic [STOCK_W-1:0]   rd_data;
  logic [NUM_ITEMS-1:0] zero;

  modport master (output reload, dec, idx, input rd_data, zero);
  modport slave  (input reload, dec, idx, output rd_data, zero);

endinterface

// File: rtl/vend_stock_bank.sv
// rtl/vend_stock_bank.sv - per-item stock counters with reload, decrement, read and zero flags
module vend_stock_bank #(
  parameter int NUM_ITEMS  = 20,
  parameter int IDX_W      = 5,
  parameter int STOCK_W    = 4,
  parameter int RELOAD_VAL = 10
) (
  input  logic              clk,
  input  logic              rst,
  vend_controller_if.slave  sb
);

  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_q;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_d;

  // Reload overrides everything; a decrement only touches the addressed nonzero slot.
  always_comb begin
    stock_d = stock_q;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sb.reload) begin
        stock_d[i] = STOCK_W'(RELOAD_VAL);
      end else if (sb.dec && (sb.idx == IDX_W'(i)) && (stock_q[i] != '0)) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end
    end
  end

  // Indexed read (zero for unmapped indices) and the per-item empty flags.
  always_comb begin
    sb.rd_data = '0;
    sb.zero    = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sb.idx == IDX_W'(i)) begin
        sb.rd_data = stock_q[i];
      end
      sb.zero[i] = (stock_q[i] == '0);
    end
  end

  // Stock register; reset empties every slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stock_q <= '0;
    end else begin
      stock_q <= stock_d;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - keypad vending controller FSM with registered outputs
module vend_controller
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS   = 20,
  parameter int CODE_DIGITS = 2,
  parameter int STOCK_W     = 4,
  parameter int RELOAD_VAL  = 10,
  parameter int PRICE_GROUP = DEF_PRICE_GROUP,
  parameter int COST_W      = 3,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CARD_IN,
  input  logic                 VALID_TRAN,
  input  logic                 KEY_PRESS,
  input  logic                 DOOR_OPEN,
  input  logic                 RELOAD,
  input  logic [3:0]           ITEM_CODE,
  output logic                 VEND,
  output logic                 INVALID_SEL,
  output logic                 FAILED_TRAN,
  output logic [COST_W-1:0]    COST,
  output logic [NUM_ITEMS-1:0] SOLD_OUT
);

  localparam int ITEM_W   = clog2_min1(10 ** CODE_DIGITS);
  localparam int IDX_W    = clog2_min1(NUM_ITEMS);
  localparam int DIGIT_W  = clog2_min1(CODE_DIGITS + 1);
  localparam int WAIT_W   = clog2_min1(TIMEOUT + 1);
  localparam int COST_MAX = (1 << COST_W) - 1;

  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(CODE_DIGITS - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [ITEM_W-1:0]    item_q, item_d;
  logic [DIGIT_W-1:0]   digit_q, digit_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 vend_q, vend_d;
  logic                 inv_q, inv_d;
  logic                 fail_q, fail_d;
  logic [COST_W-1:0]    cost_q, cost_d;
  logic [NUM_ITEMS-1:0] sold_out_q, sold_out_d;

  logic                 timed_out;
  logic                 in_range;
  logic [31:0]          cost_full;
  logic [COST_W-1:0]    cost_sat;

  vend_controller_if #(
    .NUM_ITEMS (NUM_ITEMS),
    .IDX_W     (IDX_W),
    .STOCK_W   (STOCK_W)
  ) stock_if ();

  vend_stock_bank #(
    .NUM_ITEMS  (NUM_ITEMS),
    .IDX_W      (IDX_W),
    .STOCK_W    (STOCK_W),
    .RELOAD_VAL (RELOAD_VAL)
  ) u_bank (
    .clk (CLK),
    .rst (RESET),
    .sb  (stock_if.slave)
  );

  assign stock_if.reload = (state_q == ST_RELOAD);
  assign stock_if.dec    = (state_q == ST_VEND);
  assign stock_if.idx    = item_q[IDX_W-1:0];

  // Next-state, keypad accumulation, pulse and cost decisions.
  always_comb begin
    state_d    = state_q;
    item_d     = item_q;
    digit_d    = digit_q;
    cost_d     = cost_q;
    inv_d      = 1'b0;
    fail_d     = 1'b0;
    sold_out_d = stock_if.zero;
    timed_out  = (wait_q == WAIT_LAST);
    in_range   = (32'(item_q) < 32'(NUM_ITEMS));
    cost_full  = 32'(item_q) / 32'(PRICE_GROUP) + 32'd1;
    cost_sat   = (cost_full > 32'(COST_MAX)) ? COST_W'(COST_MAX) : cost_full[COST_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (RELOAD) begin
          state_d = ST_RELOAD;
        end else if (CARD_IN) begin
          state_d = ST_GETCODE;
          item_d  = '0;
          digit_d = '0;
        end
      end
      ST_RELOAD: state_d = ST_IDLE;
      ST_GETCODE: begin
        if (!CARD_IN) begin
          state_d = ST_IDLE;
        end else if (KEY_PRESS) begin
          if (ITEM_CODE > 4'd9) begin
            inv_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            item_d  = item_q * ITEM_W'(10) + ITEM_W'(ITEM_CODE);
            digit_d = digit_q + DIGIT_W'(1);
            if (digit_q == DIGIT_LAST) begin
              state_d = ST_VALIDATE;
            end
          end
        end else if (timed_out) begin
          inv_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_VALIDATE: begin
        if (!in_range || (stock_if.rd_data == '0)) begin
          inv_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cost_d  = cost_sat;
          state_d = ST_TRANSACT;
        end
      end
      ST_TRANSACT: begin
        if (VALID_TRAN) begin
          state_d = ST_VEND;
        end else if (timed_out) begin
          fail_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_VEND: state_d = ST_DOOR_OPEN_WAIT;
      ST_DOOR_OPEN_WAIT: begin
        if (DOOR_OPEN) begin
          state_d = ST_DOOR_CLOSE_WAIT;
        end else if (timed_out) begin
          state_d = ST_IDLE;
        end
      end
      ST_DOOR_CLOSE_WAIT: begin
        if (!DOOR_OPEN) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      cost_d = '0;
    end
    vend_d = (state_d == ST_VEND);

    if ((state_d != state_q) || ((state_q == ST_GETCODE) && KEY_PRESS)) begin
      wait_d = '0;
    end else if ((state_q == ST_GETCODE) || (state_q == ST_TRANSACT) ||
                 (state_q == ST_DOOR_OPEN_WAIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      item_q     <= '0;
      digit_q    <= '0;
      wait_q     <= '0;
      vend_q     <= 1'b0;
      inv_q      <= 1'b0;
      fail_q     <= 1'b0;
      cost_q     <= '0;
      sold_out_q <= '1;
    end else begin
      state_q    <= state_d;
      item_q     <= item_d;
      digit_q    <= digit_d;
      wait_q     <= wait_d;
      vend_q     <= vend_d;
      inv_q      <= inv_d;
      fail_q     <= fail_d;
      cost_q     <= cost_d;
      sold_out_q <= sold_out_d;
    end
  end

  assign VEND        = vend_q;
  assign INVALID_SEL = inv_q;
  assign FAILED_TRAN = fail_q;
  assign COST        = cost_q;
  assign SOLD_OUT    = sold_out_q;

endmodule
